// File: rtl/param_ping_pong_counter_pkg.sv
// Shared constants for the parametrised ping-pong counter.
// Count modes and direction encodings.
package ppc_pkg;

    localparam logic [1:0] MODE_PINGPONG = 2'b00;
    localparam logic [1:0] MODE_WRAP     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT  = 2'b10;
    localparam logic [1:0] MODE_HOLD     = 2'b11;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/param_ping_pong_counter_step.sv
// Next-count arithmetic for one advance of the ping-pong counter.
// Works at WIDTH+1 bits so overshoot past a bound is visible.
module ppc_step
    import ppc_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 2
) (
    input  logic [WIDTH-1:0]  count_i,
    input  logic              dir_i,
    input  logic [STEP_W-1:0] s_i,
    input  logic [WIDTH-1:0]  min_i,
    input  logic [WIDTH-1:0]  max_i,
    input  logic [1:0]        mode_i,
    output logic [WIDTH-1:0]  next_count_o,
    output logic              next_dir_o,
    output logic              hit_bound_o,
    output logic              reach_done_o
);

    localparam int EW = WIDTH + 1;

    logic [EW-1:0] cnt_e;
    logic [EW-1:0] s_e;
    logic [EW-1:0] min_e;
    logic [EW-1:0] max_e;
    logic [EW-1:0] up_t;
    logic [EW-1:0] over;
    logic [EW-1:0] under;
    logic [EW-1:0] span;
    logic          up_ovr;
    logic          dn_ovr;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH-1:0] up_refl;
    logic [WIDTH-1:0] dn_refl;

    // Candidate targets, overshoot amounts and reflected values
    always_comb begin
        cnt_e   = {1'b0, count_i};
        s_e     = EW'(s_i);
        min_e   = {1'b0, min_i};
        max_e   = {1'b0, max_i};
        span    = max_e - min_e;
        up_t    = cnt_e + s_e;
        dn_t    = WIDTH'(cnt_e - s_e);
        up_ovr  = up_t > max_e;
        dn_ovr  = cnt_e < (min_e + s_e);
        over    = up_t - max_e;
        under   = (min_e + s_e) - cnt_e;
        up_refl = (over > span) ? min_i : WIDTH'(max_e - over);
        dn_refl = (under > span) ? max_i : WIDTH'(min_e + under);
    end

    // Mode-dependent selection of next count and direction
    always_comb begin
        next_count_o = count_i;
        next_dir_o   = dir_i;
        reach_done_o = 1'b0;
        unique case (mode_i)
            MODE_PINGPONG: begin
                if (dir_i == DIR_UP) begin
                    if (up_ovr) begin
                        next_count_o = up_refl;
                        next_dir_o   = DIR_DOWN;
                    end else begin
                        next_count_o = up_t[WIDTH-1:0];
                    end
                end else begin
                    if (dn_ovr) begin
                        next_count_o = dn_refl;
                        next_dir_o   = DIR_UP;
                    end else begin
                        next_count_o = dn_t;
                    end
                end
            end
            MODE_WRAP: begin
                if (dir_i == DIR_UP) begin
                    next_count_o = up_ovr ? min_i : up_t[WIDTH-1:0];
                end else begin
                    next_count_o = dn_ovr ? max_i : dn_t;
                end
            end
            MODE_ONESHOT: begin
                if (dir_i == DIR_UP) begin
                    next_count_o = up_ovr ? max_i : up_t[WIDTH-1:0];
                    reach_done_o = (next_count_o == max_i);
                end else begin
                    next_count_o = dn_ovr ? min_i : dn_t;
                    reach_done_o = (next_count_o == min_i);
                end
            end
            default: begin
            end
        endcase
        hit_bound_o = (next_count_o == min_i) || (next_count_o == max_i);
    end

endmodule

// File: rtl/param_ping_pong_counter.sv
// Parametrised ping-pong / wrap / one-shot counter between runtime bounds.
// Holds state registers, priority logic and the mode-change detector.
module param_ping_pong_counter
    import ppc_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              enable,
    input  logic              flip,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  max,
    input  logic [WIDTH-1:0]  min,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    output logic [WIDTH-1:0]  count,
    output logic              direction,
    output logic              bound_hit,
    output logic              done,
    output logic              range_err
);

    logic [WIDTH-1:0]  count_q, count_d;
    logic              dir_q, dir_d;
    logic              hit_q, hit_d;
    logic              done_q, done_d;
    logic [1:0]        mode_q;
    logic [STEP_W-1:0] s;
    logic              d;
    logic              adv;
    logic              mode_chg;
    logic [WIDTH-1:0]  nxt_count;
    logic              nxt_dir;
    logic              nxt_hit;
    logic              nxt_done;

    ppc_step #(
        .WIDTH (WIDTH),
        .STEP_W(STEP_W)
    ) u_step (
        .count_i     (count_q),
        .dir_i       (d),
        .s_i         (s),
        .min_i       (min),
        .max_i       (max),
        .mode_i      (mode),
        .next_count_o(nxt_count),
        .next_dir_o  (nxt_dir),
        .hit_bound_o (nxt_hit),
        .reach_done_o(nxt_done)
    );

    // Range check, effective step/direction and advance qualification
    always_comb begin
        range_err = (max <= min) || (count_q < min) || (count_q > max);
        s         = (step == '0) ? STEP_W'(1) : step;
        d         = (flip && !range_err) ? ~dir_q : dir_q;
        mode_chg  = (mode != mode_q);
        adv       = tick && enable && !range_err
                    && (mode != MODE_HOLD) && !done_q;
    end

    // Next-state selection: load beats advance/flip
    always_comb begin
        count_d = count_q;
        dir_d   = d;
        hit_d   = 1'b0;
        done_d  = mode_chg ? 1'b0 : done_q;
        if (load) begin
            count_d = load_value;
            dir_d   = dir_q;
            done_d  = 1'b0;
        end else if (adv) begin
            count_d = nxt_count;
            dir_d   = nxt_dir;
            hit_d   = nxt_hit;
            if (nxt_done) begin
                done_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset to the lower bound
    always_ff @(posedge clk) begin
        mode_q <= mode;
        if (reset) begin
            count_q <= min;
            dir_q   <= DIR_UP;
            hit_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            hit_q   <= hit_d;
            done_q  <= done_d;
        end
    end

    assign count     = count_q;
    assign direction = dir_q;
    assign bound_hit = hit_q;
    assign done      = done_q;

endmodule

// File: tb/tb_param_ping_pong_counter.sv
// Directed, table-driven bench for param_ping_pong_counter.
// Each record is applied for one clock and its outputs checked after the edge.
module tb_param_ping_pong_counter;

    localparam int W  = 4;
    localparam int SW = 2;

    typedef struct {
        logic          rst;
        logic          tk;
        logic          en;
        logic          fl;
        logic [1:0]    md;
        logic [SW-1:0] st;
        logic [W-1:0]  mx;
        logic [W-1:0]  mn;
        logic          ld;
        logic [W-1:0]  lv;
        logic [W-1:0]  ec;
        logic          ed;
        logic          eh;
        logic          edn;
        logic          ee;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset, tick, enable, flip, load;
    logic [1:0]    mode;
    logic [SW-1:0] step;
    logic [W-1:0]  max, min, load_value;
    logic [W-1:0]  count;
    logic          direction, bound_hit, done, range_err;

    int n_chk  = 0;
    int n_fail = 0;
    vec_t vq[$];

    param_ping_pong_counter #(.WIDTH(W), .STEP_W(SW)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .enable    (enable),
        .flip      (flip),
        .mode      (mode),
        .step      (step),
        .max       (max),
        .min       (min),
        .load      (load),
        .load_value(load_value),
        .count     (count),
        .direction (direction),
        .bound_hit (bound_hit),
        .done      (done),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    task automatic add(input logic rst, input logic tk, input logic en,
                       input logic fl, input logic [1:0] md,
                       input logic [SW-1:0] st, input logic [W-1:0] mx,
                       input logic [W-1:0] mn, input logic ld,
                       input logic [W-1:0] lv, input logic [W-1:0] ec,
                       input logic ed, input logic eh, input logic edn,
                       input logic ee);
        vec_t v;
        v.rst = rst; v.tk = tk; v.en = en; v.fl = fl; v.md = md;
        v.st = st; v.mx = mx; v.mn = mn; v.ld = ld; v.lv = lv;
        v.ec = ec; v.ed = ed; v.eh = eh; v.edn = edn; v.ee = ee;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input int act,
                       input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got %0d expected %0d", idx, nm, act, exp);
        end
    endtask

    initial begin
        reset = 1'b0; tick = 1'b0; enable = 1'b0; flip = 1'b0;
        load = 1'b0; mode = 2'b00; step = '0; max = '0; min = '0;
        load_value = '0;

        // 1: ping-pong 0..9..0..1, step 1
        add(1,1,1,0, 2'b00,1, 9,0, 0,0,  0,1,0,0,0);
        for (int k = 1; k <= 19; k++) begin
            int c;
            c = (k <= 9) ? k : ((k <= 18) ? 18 - k : k - 18);
            add(0,1,1,0, 2'b00,1, 9,0, 0,0, W'(c),
                (k <= 9 || k >= 19), (k == 9 || k == 18), 0, 0);
        end
        // 2: climb to 5, flip with tick, flip while disabled / no tick
        add(0,1,1,0, 2'b00,1, 9,0, 0,0,  2,1,0,0,0);
        add(0,1,1,0, 2'b00,1, 9,0, 0,0,  3,1,0,0,0);
        add(0,1,1,0, 2'b00,1, 9,0, 0,0,  4,1,0,0,0);
        add(0,1,1,0, 2'b00,1, 9,0, 0,0,  5,1,0,0,0);
        add(0,1,1,1, 2'b00,1, 9,0, 0,0,  4,0,0,0,0);
        add(0,1,0,1, 2'b00,1, 9,0, 0,0,  4,1,0,0,0);
        add(0,0,1,1, 2'b00,1, 9,0, 0,0,  4,0,0,0,0);
        // 3: wrap, min 3 max 6 step 2
        add(0,1,1,0, 2'b01,2, 6,3, 1,3,  3,0,0,0,0);
        add(0,0,1,1, 2'b01,2, 6,3, 0,0,  3,1,0,0,0);
        add(0,1,1,0, 2'b01,2, 6,3, 0,0,  5,1,0,0,0);
        add(0,1,1,0, 2'b01,2, 6,3, 0,0,  3,1,1,0,0);
        add(0,1,1,1, 2'b01,2, 6,3, 0,0,  6,0,1,0,0);
        // 4: one-shot, min 0 max 7 step 3
        add(0,1,1,0, 2'b10,3, 7,0, 1,0,  0,0,0,0,0);
        add(0,0,1,1, 2'b10,3, 7,0, 0,0,  0,1,0,0,0);
        add(0,1,1,0, 2'b10,3, 7,0, 0,0,  3,1,0,0,0);
        add(0,1,1,0, 2'b10,3, 7,0, 0,0,  6,1,0,0,0);
        add(0,1,1,0, 2'b10,3, 7,0, 0,0,  7,1,1,1,0);
        for (int k = 0; k < 5; k++)
            add(0,1,1,0, 2'b10,3, 7,0, 0,0,  7,1,0,1,0);
        add(0,1,1,1, 2'b10,3, 7,0, 0,0,  7,0,0,1,0);
        add(0,1,1,0, 2'b11,3, 7,0, 0,0,  7,0,0,0,0);
        add(0,0,1,0, 2'b10,3, 7,0, 0,0,  7,0,0,0,0);
        add(0,1,1,0, 2'b10,3, 7,0, 1,2,  2,0,0,0,0);
        add(0,1,1,0, 2'b10,0, 7,0, 0,0,  1,0,0,0,0);
        add(0,1,1,0, 2'b10,0, 7,0, 0,0,  0,0,1,1,0);
        // 5: range error freeze and recovery, out-of-range load
        add(0,1,1,0, 2'b00,1, 9,0, 1,5,  5,0,0,0,0);
        add(0,1,1,0, 2'b00,1, 2,5, 0,0,  5,0,0,0,1);
        add(0,1,1,1, 2'b00,1, 2,5, 0,0,  5,0,0,0,1);
        add(0,1,1,0, 2'b00,1, 9,0, 0,0,  4,0,0,0,0);
        add(0,1,1,0, 2'b00,1, 9,0, 1,12, 12,0,0,0,1);
        add(0,1,1,1, 2'b00,1, 9,0, 0,0,  12,0,0,0,1);
        add(0,1,1,0, 2'b00,1, 9,0, 1,7,  7,0,0,0,0);
        // 6: reset with tick and flip mid-count, then nonzero min
        add(1,1,1,1, 2'b00,1, 9,0, 0,0,  0,1,0,0,0);
        add(1,1,1,0, 2'b00,1, 9,3, 0,0,  3,1,0,0,0);
        add(0,1,1,0, 2'b00,1, 9,3, 0,0,  4,1,0,0,0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            reset = vq[i].rst; tick = vq[i].tk; enable = vq[i].en;
            flip = vq[i].fl; mode = vq[i].md; step = vq[i].st;
            max = vq[i].mx; min = vq[i].mn; load = vq[i].ld;
            load_value = vq[i].lv;
            @(posedge clk);
            #1;
            chk("count",     i, int'(count),     int'(vq[i].ec));
            chk("direction", i, int'(direction), int'(vq[i].ed));
            chk("bound_hit", i, int'(bound_hit), int'(vq[i].eh));
            chk("done",      i, int'(done),      int'(vq[i].edn));
            chk("range_err", i, int'(range_err), int'(vq[i].ee));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
